pipe_hazard_unit: RTL and testbench

Parametrised hazard-detection and forwarding controller for the pipelined MIPS datapath. It keeps a shadow pipeline of destination-register tags, one per back-end stage (EX, MEM, WB at default depth), and produces per-source forwarding selects, load-use stalls, branch flushes and a halt-drain flag. It sits beside the ID stage and drives the enables and flushes of the IF/ID and ID/EX pipeline registers and the operand muxes in EX.

---
 rtl/pipe_hazard_unit.sv | 98 +++++++++
 tb/tb_pipe_hazard_unit.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_unit.sv
// rtl/pipe_hazard_unit.sv - load-use stall, forwarding select, branch flush and halt drain for the MIPS pipeline
module pipe_hazard_unit #(
    parameter int DEPTH = 3,
    parameter int NSRC  = 2,
    parameter int RSELW = 5,
    parameter int FSELW = $clog2(DEPTH + 1),
    parameter int CNTW  = 16
) (
    input  logic                    CLK,
    input  logic                    nRST,
    input  logic                    pipe_en,
    input  logic                    id_valid,
    input  logic [NSRC*RSELW-1:0]   id_rsel,
    input  logic [NSRC-1:0]         id_use,
    input  logic                    id_wen,
    input  logic                    id_load,
    input  logic                    id_halt,
    input  logic [RSELW-1:0]        id_wsel,
    input  logic                    branch_taken,
    output logic                    stall,
    output logic                    flush_ifid,
    output logic                    flush_idex,
    output logic [NSRC*FSELW-1:0]   fwd_sel,
    output logic                    halt_done,
    output logic [15:0]             stall_cnt
);

    logic [DEPTH-1:0]             e_valid;
    logic [DEPTH-1:0]             e_wen;
    logic [DEPTH-1:0]             e_halt;
    logic [DEPTH-1:0][RSELW-1:0]  e_wsel;
    // A load only matters while it sits in EX; older loads forward like any result.
    logic                         e_load0;

    logic                         halt_seen;
    logic                         halt_done_q;
    logic [CNTW-1:0]              cnt;

    logic                         load_hit;
    logic                         load_en;
    logic [RSELW-1:0]             rsel;

    // Scan oldest to youngest so the youngest matching producer overwrites the select.
    always_comb begin
        fwd_sel  = '0;
        load_hit = 1'b0;
        rsel     = '0;
        for (int i = 0; i < NSRC; i++) begin
            rsel = id_rsel[i*RSELW +: RSELW];
            for (int k = DEPTH - 1; k >= 0; k--) begin
                if (id_use[i] && (rsel != '0) && e_valid[k] && e_wen[k] && (e_wsel[k] == rsel))
                    fwd_sel[i*FSELW +: FSELW] = FSELW'(k + 1);
            end
            if (id_use[i] && (rsel != '0) && e_valid[0] && e_wen[0] && e_load0 && (e_wsel[0] == rsel))
                load_hit = 1'b1;
        end
    end

    assign stall      = id_valid & load_hit & ~branch_taken;
    assign flush_ifid = branch_taken;
    assign flush_idex = branch_taken;
    assign load_en    = id_valid & ~stall & ~branch_taken & ~halt_seen;
    assign halt_done  = halt_done_q | e_halt[DEPTH-1];
    assign stall_cnt  = 16'(cnt);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            e_valid     <= '0;
            e_wen       <= '0;
            e_halt      <= '0;
            e_wsel      <= '0;
            e_load0     <= 1'b0;
            halt_seen   <= 1'b0;
            halt_done_q <= 1'b0;
            cnt         <= '0;
        end else begin
            halt_done_q <= halt_done_q | e_halt[DEPTH-1];
            if (pipe_en) begin
                for (int k = 1; k < DEPTH; k++) begin
                    e_valid[k] <= e_valid[k-1];
                    e_wen[k]   <= e_wen[k-1];
                    e_halt[k]  <= e_halt[k-1];
                    e_wsel[k]  <= e_wsel[k-1];
                end
                e_valid[0] <= load_en;
                e_wen[0]   <= load_en & id_wen;
                e_halt[0]  <= load_en & id_halt;
                e_wsel[0]  <= load_en ? id_wsel : '0;
                e_load0    <= load_en & id_load;
                if (load_en && id_halt)
                    halt_seen <= 1'b1;
                if (stall && (cnt != '1))
                    cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// tb/tb_pipe_hazard_unit.sv - scoreboard bench for pipe_hazard_unit
module tb_pipe_hazard_unit;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        pipe_en = 1'b0;
    logic        id_valid = 1'b0;
    logic [9:0]  id_rsel = '0;
    logic [1:0]  id_use = '0;
    logic        id_wen = 1'b0;
    logic        id_load = 1'b0;
    logic        id_halt = 1'b0;
    logic [4:0]  id_wsel = '0;
    logic        branch_taken = 1'b0;

    logic        stall, flush_ifid, flush_idex, halt_done;
    logic [3:0]  fwd_sel;
    logic [15:0] stall_cnt;

    logic        s_stall, s_flush_ifid, s_flush_idex, s_halt_done;
    logic [3:0]  s_fwd_sel;
    logic [15:0] s_stall_cnt;

    typedef struct {
        logic        st;
        logic        fl;
        logic [1:0]  f0;
        logic [1:0]  f1;
        logic        hd;
        logic [15:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    pipe_hazard_unit dut (
        .CLK(CLK), .nRST(nRST), .pipe_en(pipe_en), .id_valid(id_valid),
        .id_rsel(id_rsel), .id_use(id_use), .id_wen(id_wen), .id_load(id_load),
        .id_halt(id_halt), .id_wsel(id_wsel), .branch_taken(branch_taken),
        .stall(stall), .flush_ifid(flush_ifid), .flush_idex(flush_idex),
        .fwd_sel(fwd_sel), .halt_done(halt_done), .stall_cnt(stall_cnt)
    );

    // Narrow counter copy so saturation is reachable in a short run.
    pipe_hazard_unit #(.CNTW(4)) u_sat (
        .CLK(CLK), .nRST(nRST), .pipe_en(pipe_en), .id_valid(id_valid),
        .id_rsel(id_rsel), .id_use(id_use), .id_wen(id_wen), .id_load(id_load),
        .id_halt(id_halt), .id_wsel(id_wsel), .branch_taken(branch_taken),
        .stall(s_stall), .flush_ifid(s_flush_ifid), .flush_idex(s_flush_idex),
        .fwd_sel(s_fwd_sel), .halt_done(s_halt_done), .stall_cnt(s_stall_cnt)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_miss++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    always @(negedge CLK) begin
        if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("stall", 32'(stall), 32'(e.st));
            chk("flush_ifid", 32'(flush_ifid), 32'(e.fl));
            chk("flush_idex", 32'(flush_idex), 32'(e.fl));
            chk("fwd_sel", 32'(fwd_sel), 32'({e.f1, e.f0}));
            chk("halt_done", 32'(halt_done), 32'(e.hd));
            chk("stall_cnt", 32'(stall_cnt), 32'(e.cnt));
        end
    end

    task automatic drive(input logic pe, input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [1:0] um, input logic wen, input logic ld, input logic hlt,
                         input logic [4:0] ws, input logic br,
                         input logic est, input logic efl, input logic [1:0] ef0, input logic [1:0] ef1,
                         input logic ehd, input logic [15:0] ecnt);
        exp_t e;
        pipe_en = pe; id_valid = v; id_rsel = {rt, rs}; id_use = um;
        id_wen = wen; id_load = ld; id_halt = hlt; id_wsel = ws; branch_taken = br;
        e.st = est; e.fl = efl; e.f0 = ef0; e.f1 = ef1; e.hd = ehd; e.cnt = ecnt;
        sb.push_back(e);
    endtask

    task automatic apply(input logic pe, input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [1:0] um, input logic wen, input logic ld, input logic hlt,
                         input logic [4:0] ws, input logic br,
                         input logic est, input logic efl, input logic [1:0] ef0, input logic [1:0] ef1,
                         input logic ehd, input logic [15:0] ecnt);
        drive(pe, v, rs, rt, um, wen, ld, hlt, ws, br, est, efl, ef0, ef1, ehd, ecnt);
        @(posedge CLK);
        #1;
    endtask

    initial begin
        @(negedge CLK);
        chk("rst_stall", 32'(stall), 0);
        chk("rst_fwd", 32'(fwd_sel), 0);
        chk("rst_halt", 32'(halt_done), 0);
        chk("rst_cnt", 32'(stall_cnt), 0);
        @(posedge CLK);
        #1 nRST = 1'b1;

        // RAW chain on $5 ages through EX, MEM, WB
        apply(1,1, 0,0,2'b00, 1,0,0, 5,0,  0,0,0,0,0,0);
        apply(1,1, 5,0,2'b01, 0,0,0, 0,0,  0,0,1,0,0,0);
        apply(1,1, 5,0,2'b01, 0,0,0, 0,0,  0,0,2,0,0,0);
        apply(1,1, 5,0,2'b01, 0,0,0, 0,0,  0,0,3,0,0,0);
        apply(1,1, 5,0,2'b01, 0,0,0, 0,0,  0,0,0,0,0,0);

        // youngest producer wins; $0 never forwards
        apply(1,1, 0,0,2'b00, 1,0,0, 8,0,  0,0,0,0,0,0);
        apply(1,1, 0,0,2'b00, 1,0,0, 9,0,  0,0,0,0,0,0);
        apply(1,1, 0,0,2'b00, 1,0,0, 8,0,  0,0,0,0,0,0);
        apply(1,1, 9,8,2'b11, 1,0,0, 0,0,  0,0,2,1,0,0);
        apply(1,1, 0,8,2'b11, 0,0,0, 0,0,  0,0,0,2,0,0);

        // load-use: one stall then forward from MEM
        apply(1,1, 0,0,2'b00, 1,1,0, 3,0,  0,0,0,0,0,0);
        apply(1,1, 3,0,2'b01, 0,0,0, 0,0,  1,0,1,0,0,0);
        apply(1,1, 3,0,2'b01, 0,0,0, 0,0,  0,0,2,0,0,1);
        apply(1,0, 0,0,2'b00, 0,0,0, 0,0,  0,0,0,0,0,1);

        // branch beats stall, then bubble in EX
        apply(1,1, 0,0,2'b00, 1,1,0, 4,0,  0,0,0,0,0,1);
        apply(1,1, 4,0,2'b01, 0,0,0, 0,1,  0,1,1,0,0,1);
        apply(1,1, 4,0,2'b01, 0,0,0, 0,0,  0,0,2,0,0,1);

        // frozen pipeline keeps the stall but does not count it
        apply(1,1, 0,0,2'b00, 1,1,0, 6,0,  0,0,0,0,0,1);
        for (int i = 0; i < 5; i++)
            apply(0,1, 6,0,2'b01, 0,0,0, 0,0,  1,0,1,0,0,1);
        apply(1,1, 6,0,2'b01, 0,0,0, 0,0,  1,0,1,0,0,1);

        // HALT drains; later instructions are dropped
        apply(1,1, 0,0,2'b00, 0,0,1, 0,0,  0,0,0,0,0,2);
        apply(1,1, 0,0,2'b00, 1,0,0, 7,0,  0,0,0,0,0,2);
        apply(1,1, 7,0,2'b01, 0,0,0, 0,0,  0,0,0,0,0,2);
        apply(1,1, 7,0,2'b01, 0,0,0, 0,0,  0,0,0,0,1,2);
        apply(1,1, 0,0,2'b00, 1,1,0, 7,0,  0,0,0,0,1,2);
        apply(1,1, 7,0,2'b01, 0,0,0, 0,0,  0,0,0,0,1,2);

        nRST = 1'b0;
        #3;
        chk("rst2_halt", 32'(halt_done), 0);
        chk("rst2_cnt", 32'(stall_cnt), 0);
        nRST = 1'b1;
        @(posedge CLK);
        #1;

        // reset mid-operation with all entries valid
        apply(1,1, 0,0,2'b00, 1,0,0, 10,0,  0,0,0,0,0,0);
        apply(1,1, 0,0,2'b00, 1,0,0, 11,0,  0,0,0,0,0,0);
        apply(1,1, 0,0,2'b00, 1,1,0, 12,0,  0,0,0,0,0,0);
        apply(1,1, 12,11,2'b11, 0,0,0, 0,0,  1,0,1,2,0,0);
        drive(1,1, 12,11,2'b11, 0,0,0, 0,0,  0,0,2,3,0,1);
        @(negedge CLK);
        #1 nRST = 1'b0;
        #1;
        chk("arst_stall", 32'(stall), 0);
        chk("arst_flush", 32'({flush_ifid, flush_idex}), 0);
        chk("arst_fwd", 32'(fwd_sel), 0);
        chk("arst_halt", 32'(halt_done), 0);
        chk("arst_cnt", 32'(stall_cnt), 0);
        @(posedge CLK);
        #1 nRST = 1'b1;
        apply(1,1, 12,11,2'b11, 0,0,0, 0,0,  0,0,0,0,0,0);

        // repeated load-use to drive the counters
        apply(1,1, 13,0,2'b01, 1,1,0, 13,0,  0,0,0,0,0,0);
        for (int i = 0; i < 20; i++) begin
            apply(1,1, 13,0,2'b01, 1,1,0, 13,0,  1,0,1,0,0,16'(i));
            apply(1,1, 13,0,2'b01, 1,1,0, 13,0,  0,0,2,0,0,16'(i + 1));
        end
        chk("cnt_main", 32'(stall_cnt), 20);
        chk("cnt_sat", 32'(s_stall_cnt), 15);
        @(negedge CLK);
        #1;
        chk("sb_drain", 32'(sb.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
